note_judge: RTL

- Sits downstream of the drop-notes datapath.
- Consumes the 5-bit bottom-row note vector and the eighth-note beat pulse, and compares them with the player's fret buttons and strum bar.
- Issues hit/miss pulses and keeps the score, combo and multiplier for the HUD/score display stage.
- One judgement per beat that carries at least one note.

---
 rtl/note_judge.sv | 114 +++++++++++
 1 files changed

// File: rtl/note_judge.sv
// Strum judge: opens a timing window per non-empty beat, grades the strum, keeps score/combo/mult.
// Optional NOTE_JUDGE_OVERSTRUM_PENALTY_EN: a strum with no open window counts as a miss.
module note_judge #(
    parameter int unsigned WINDOW_CYCLES = 2000000,
    parameter int unsigned SCORE_W       = 16,
    parameter int unsigned COMBO_W       = 8,
    parameter int unsigned HIT_POINTS    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_beat,
    input  logic [4:0]         i_notes_to_play,
    input  logic [4:0]         i_frets,
    input  logic               i_strum,
    output logic               o_hit,
    output logic               o_miss,
    output logic [SCORE_W-1:0] o_score,
    output logic [COMBO_W-1:0] o_combo,
    output logic [2:0]         o_multiplier,
    output logic               o_judging
);

    localparam int unsigned TIMER_W = $clog2(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WINDOW_CYCLES - 1);

    typedef enum logic {StIdle, StWindow} state_e;

    state_e             state;
    logic [4:0]         target;
    logic               strum_d;
    logic [TIMER_W-1:0] timer;

    logic               strum_edge;
    logic               in_window;
    logic               chord_ok;
    logic               open_window;
    logic               judge_hit;
    logic               judge_miss;
    logic               overstrum;
    logic               take_miss;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [COMBO_W-1:0] combo_inc;

    function automatic logic [2:0] mult_for(input logic [COMBO_W-1:0] c);
        if (32'(c) >= 30)      return 3'd4;
        else if (32'(c) >= 20) return 3'd3;
        else if (32'(c) >= 10) return 3'd2;
        else                   return 3'd1;
    endfunction

    always_comb begin
        strum_edge  = i_strum & ~strum_d;
        in_window   = (state == StWindow);
        chord_ok    = (i_frets == target);
        open_window = i_beat & (|i_notes_to_play);
        judge_hit   = in_window & strum_edge & chord_ok;
        // A beat arriving mid-window closes the old window as a miss before reopening.
        judge_miss  = in_window & (strum_edge ? ~chord_ok : (i_beat | (timer == '0)));
`ifdef NOTE_JUDGE_OVERSTRUM_PENALTY_EN
        overstrum   = ~in_window & strum_edge;
`else
        overstrum   = 1'b0;
`endif
        take_miss   = judge_miss | overstrum;
        score_sum   = {1'b0, o_score} + (SCORE_W + 1)'(HIT_POINTS * 32'(o_multiplier));
        score_next  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        combo_inc   = (&o_combo) ? o_combo : o_combo + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            target       <= '0;
            strum_d      <= 1'b0;
            timer        <= '0;
            o_hit        <= 1'b0;
            o_miss       <= 1'b0;
            o_score      <= '0;
            o_combo      <= '0;
            o_multiplier <= 3'd1;
            o_judging    <= 1'b0;
        end else begin
            strum_d <= i_strum;
            o_hit   <= judge_hit;
            o_miss  <= take_miss;

            // Score uses the multiplier in force before this hit.
            if (judge_hit) begin
                o_score      <= score_next;
                o_combo      <= combo_inc;
                o_multiplier <= mult_for(combo_inc);
            end else if (take_miss) begin
                o_combo      <= '0;
                o_multiplier <= 3'd1;
            end

            if (open_window) begin
                state     <= StWindow;
                target    <= i_notes_to_play;
                timer     <= TIMER_LOAD;
                o_judging <= 1'b1;
            end else if (in_window) begin
                if (judge_hit || judge_miss) begin
                    state     <= StIdle;
                    o_judging <= 1'b0;
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

endmodule
